fp_accum_ctrl: RTL and testbench

Streaming floating-point accumulator controller that acts as the initiator for the single-precision `Adder`. It accepts a stream of IEEE-754 binary32 operands on a valid/ready input and issues one `Adder` operation per operand after the first. Each operation is an `En` pulse followed by a wait for `Ready`, with `Sum` fed back as the next `A`. The final sum is presented on a valid/ready output together with the element count and a timeout error flag.

---
 rtl/fp_accum_ctrl_if.sv | 26 ++
 rtl/fp_accum_ctrl.sv | 104 ++++++++++
 tb/tb_fp_accum_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fp_accum_ctrl_if.sv
// fp_accum_ctrl_if: operand stream, adder initiator and result stream signals
interface fp_accum_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0]      In_Data;
  logic             In_Valid;
  logic             In_Last;
  logic             In_Ready;
  logic [31:0]      Add_A;
  logic [31:0]      Add_B;
  logic             Add_En;
  logic [31:0]      Add_Sum;
  logic             Add_Ready;
  logic [31:0]      Out_Sum;
  logic [CNT_W-1:0] Out_Count;
  logic             Out_Error;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Busy;
  modport master (
    input  In_Data, In_Valid, In_Last, Add_Sum, Add_Ready, Out_Ready,
    output In_Ready, Add_A, Add_B, Add_En, Out_Sum, Out_Count, Out_Error, Out_Valid, Busy
  );
  modport slave (
    output In_Data, In_Valid, In_Last, Add_Sum, Add_Ready, Out_Ready,
    input  In_Ready, Add_A, Add_B, Add_En, Out_Sum, Out_Count, Out_Error, Out_Valid, Busy
  );
endinterface

// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: streams binary32 operands through an external adder, returns sum/count/error
module fp_accum_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input logic         clk,
  input logic         reset,
  fp_accum_ctrl_if.master bus
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, OUTPUT} state_t;
  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d, last_q, last_d, drain_q, drain_d, rdy_q;
  logic             accept, timeout;
  assign accept  = bus.In_Valid & rdy_q;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign timeout = to_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign bus.In_Ready  = rdy_q;
  assign bus.Add_A     = a_q;
  assign bus.Add_B     = b_q;
  assign bus.Add_En    = state_q == ISSUE;
  assign bus.Out_Valid = state_q == OUTPUT;
  assign bus.Out_Sum   = state_q == OUTPUT ? acc_q : '0;
  assign bus.Out_Count = state_q == OUTPUT ? cnt_q : '0;
  assign bus.Out_Error = state_q == OUTPUT && err_q;
  assign bus.Busy      = state_q != IDLE;
  // next-state: accept operands, issue one add per operand, capture or time out, drain after error
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    err_d   = err_q;
    last_d  = last_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d   = bus.In_Data;
        cnt_d   = CNT_W'(1);
        err_d   = 1'b0;
        drain_d = 1'b0;
        state_d = bus.In_Last ? OUTPUT : FETCH;
      end
      FETCH: if (accept) begin
        cnt_d = cnt_inc;
        if (drain_q) state_d = bus.In_Last ? OUTPUT : FETCH;
        else begin
          a_d     = acc_q;
          b_d     = bus.In_Data;
          last_d  = bus.In_Last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        to_d = to_q + 1'b1;
        if (to_q != '0 && bus.Add_Ready) begin
          acc_d   = bus.Add_Sum;
          state_d = last_q ? OUTPUT : FETCH;
        end else if (timeout) begin
          err_d   = 1'b1;
          drain_d = !last_q;
          state_d = last_q ? OUTPUT : FETCH;
        end
      end
      OUTPUT: if (bus.Out_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; input ready is registered so it stays low during reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      drain_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      err_q   <= err_d;
      last_q  <= last_d;
      drain_q <= drain_d;
      rdy_q   <= state_d == IDLE || state_d == FETCH;
    end
  end
endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb_fp_accum_ctrl: directed vectors against a behavioural adder with configurable latency
module tb_fp_accum_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   lat = 3;
  bit   never = 1'b0;
  bit   stale = 1'b0;
  int   e = 0;
  int   cyc = 0;
  int   n_en = 0;
  int   en_cyc = 0;
  int   ov_cyc = 0;
  int   passed = 0;
  int   total = 0;
  logic [31:0] pa [0:63];
  logic [31:0] pb [0:63];
  typedef struct {
    logic [2:0][31:0] d;
    int               n;
    int               lat;
    bit               never;
    logic [31:0]      sum;
    int               cnt;
    bit               err;
    int               nen;
    logic [31:0]      a0, b0, a1, b1;
  } vec_t;
  vec_t v [4];
  always #5 clk = ~clk;
  fp_accum_ctrl_if #(.CNT_W(16)) bus();
  fp_accum_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [31:0] add_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h40400000, 32'h40800000}: return 32'h40E00000;
      {32'h41200000, 32'h40A00000}: return 32'h41700000;
      default:                      return 32'hBAD0BAD0;
    endcase
  endfunction
  assign bus.Add_Ready = !never && (e >= lat || (stale && e <= 1));
  assign bus.Add_Sum   = e >= lat ? add_ref(bus.Add_A, bus.Add_B) : 32'hBAD0BAD0;
  // adder model: cycles elapsed since the last En pulse
  always @(posedge clk) e <= bus.Add_En ? 1 : (e < 1000 ? e + 1 : e);
  // cycle counter and log of issued operand pairs
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && bus.Add_En) begin
      if (n_en < 64) begin
        pa[n_en] = bus.Add_A;
        pb[n_en] = bus.Add_B;
      end
      n_en   = n_en + 1;
      en_cyc = cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    bus.In_Data  = d;
    bus.In_Valid = 1'b1;
    bus.In_Last  = last;
    while (!bus.In_Ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'b0, bus.In_Ready}, 1);
    @(negedge clk);
    bus.In_Valid = 1'b0;
    bus.In_Last  = 1'b0;
  endtask
  task automatic get_out(input logic [31:0] sum, input int cnt, input bit err);
    int n = 0;
    while (!bus.Out_Valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    ov_cyc = cyc;
    chk("out_valid", {31'b0, bus.Out_Valid}, 1);
    chk("out_sum", bus.Out_Sum, sum);
    chk("out_count", {16'b0, bus.Out_Count}, cnt);
    chk("out_error", {31'b0, bus.Out_Error}, {31'b0, err});
    bus.Out_Ready = 1'b1;
    @(negedge clk);
    bus.Out_Ready = 1'b0;
    chk("in_ready_after_out", {31'b0, bus.In_Ready}, 1);
  endtask
  initial begin
    int base;
    logic [31:0] s;
    logic [15:0] c;
    bit ok;
    bus.In_Data   = '0;
    bus.In_Valid  = 1'b0;
    bus.In_Last   = 1'b0;
    bus.Out_Ready = 1'b0;
    v[0] = '{d: {32'h0, 32'h0, 32'h3F800000}, n: 1, lat: 3, never: 0, sum: 32'h3F800000, cnt: 1, err: 0, nen: 0,
             a0: 32'h0, b0: 32'h0, a1: 32'h0, b1: 32'h0};
    v[1] = '{d: {32'h40800000, 32'h40000000, 32'h3F800000}, n: 3, lat: 3, never: 0, sum: 32'h40E00000, cnt: 3, err: 0, nen: 2,
             a0: 32'h3F800000, b0: 32'h40000000, a1: 32'h40400000, b1: 32'h40800000};
    v[2] = '{d: {32'h0, 32'h40A00000, 32'h41200000}, n: 2, lat: 4, never: 0, sum: 32'h41700000, cnt: 2, err: 0, nen: 1,
             a0: 32'h41200000, b0: 32'h40A00000, a1: 32'h0, b1: 32'h0};
    v[3] = '{d: {32'h40800000, 32'h40000000, 32'h3F800000}, n: 3, lat: 3, never: 1, sum: 32'h3F800000, cnt: 3, err: 1, nen: 1,
             a0: 32'h3F800000, b0: 32'h40000000, a1: 32'h0, b1: 32'h0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.In_Ready}, 0);
    chk("rst_busy", {31'b0, bus.Busy}, 0);
    chk("rst_add_en", {31'b0, bus.Add_En}, 0);
    chk("rst_out_valid", {31'b0, bus.Out_Valid}, 0);
    chk("rst_add_a", bus.Add_A, 0);
    chk("rst_add_b", bus.Add_B, 0);
    chk("rst_out_sum", bus.Out_Sum, 0);
    chk("rst_out_count", {16'b0, bus.Out_Count}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, bus.In_Ready}, 1);
    for (int i = 0; i < 4; i++) begin
      lat   = v[i].lat;
      never = v[i].never;
      base  = n_en;
      for (int j = 0; j < v[i].n; j++) send(v[i].d[j], j == v[i].n - 1);
      if (v[i].n == 1) chk("single_valid_next", {31'b0, bus.Out_Valid}, 1);
      get_out(v[i].sum, v[i].cnt, v[i].err);
      chk("en_pulses", n_en - base, v[i].nen);
      if (v[i].nen > 0) begin
        chk("pair0_a", pa[base], v[i].a0);
        chk("pair0_b", pb[base], v[i].b0);
      end
      if (v[i].nen > 1) begin
        chk("pair1_a", pa[base + 1], v[i].a1);
        chk("pair1_b", pb[base + 1], v[i].b1);
      end
    end
    never = 1'b0;
    lat   = 5;
    stale = 1'b1;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    get_out(32'h40400000, 2, 1'b0);
    chk("stale_capture_delay", ov_cyc - en_cyc, 6);
    stale = 1'b0;
    lat   = 3;
    send(32'h40800000, 1'b1);
    s = bus.Out_Sum;
    c = bus.Out_Count;
    bus.In_Data  = 32'h41200000;
    bus.In_Valid = 1'b1;
    bus.In_Last  = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.Out_Valid !== 1'b1 || bus.Out_Sum !== s || bus.Out_Count !== c || bus.In_Ready !== 1'b0) ok = 1'b0;
    end
    bus.In_Valid = 1'b0;
    bus.In_Last  = 1'b0;
    chk("hold_stable", {31'b0, ok}, 1);
    get_out(32'h40800000, 1, 1'b0);
    never = 1'b1;
    send(32'h41200000, 1'b0);
    send(32'h40A00000, 1'b1);
    repeat (3) @(negedge clk);
    chk("mid_wait_busy", {31'b0, bus.Busy}, 1);
    reset = 1'b0;
    #1;
    chk("abort_add_en", {31'b0, bus.Add_En}, 0);
    chk("abort_add_a", bus.Add_A, 0);
    chk("abort_add_b", bus.Add_B, 0);
    chk("abort_busy", {31'b0, bus.Busy}, 0);
    chk("abort_out_valid", {31'b0, bus.Out_Valid}, 0);
    chk("abort_in_ready", {31'b0, bus.In_Ready}, 0);
    chk("abort_out_count", {16'b0, bus.Out_Count}, 0);
    @(negedge clk);
    reset = 1'b1;
    never = 1'b0;
    @(negedge clk);
    send(32'h41200000, 1'b0);
    send(32'h40A00000, 1'b1);
    get_out(32'h41700000, 2, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
